// File: rtl/hi_simulate_fsk.sv
// ISO15693 tag-side FSK load modulator fed with 2-bit chip codes over SSP.
// Optional build macro HI_SIM_FSK_UNDERRUN_STATUS_EN adds a sticky underrun status on ssp_din.
module hi_simulate_fsk #(
  parameter int SSP_DIV = 32,
  parameter int DIV0    = 32,
  parameter int CYC0    = 8,
  parameter int DIV1    = 28,
  parameter int CYC1    = 9,
  parameter int SIL_LEN = 256
) (
  input  logic ck_1356meg,
  input  logic reset_n,
  input  logic ssp_dout,
  output logic ssp_clk,
  output logic ssp_frame,
  output logic ssp_din,
  output logic pwr_oe1,
  output logic pwr_lo,
  output logic pwr_hi,
  output logic pwr_oe2,
  output logic pwr_oe3,
  output logic pwr_oe4,
  output logic adc_clk
);

  localparam int SSP_W = $clog2(SSP_DIV);
  localparam logic [SSP_W-1:0] SSP_LAST = SSP_W'(SSP_DIV - 1);
  localparam logic [SSP_W-1:0] SSP_HALF = SSP_W'(SSP_DIV / 2);
  localparam logic [4:0] D0_M1  = 5'(DIV0 - 1);
  localparam logic [4:0] D0_H   = 5'(DIV0 / 2);
  localparam logic [4:0] D1_M1  = 5'(DIV1 - 1);
  localparam logic [4:0] D1_H   = 5'(DIV1 / 2);
  localparam logic [3:0] C0_M1  = 4'(CYC0 - 1);
  localparam logic [3:0] C1_M1  = 4'(CYC1 - 1);
  localparam logic [8:0] SIL_M1 = 9'(SIL_LEN - 1);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  logic [SSP_W-1:0] r_sspCnt;
  logic             r_sspClk;
  logic [2:0]       r_bitIdx;
  logic             r_slotReq;
  logic [6:0]       r_rx;
  logic             r_holdValid;
  logic [7:0]       r_hold;

  state_t     r_state, w_stateNext;
  logic [7:0] r_shift, w_shiftNext;
  logic [1:0] r_chipIdx, w_chipIdxNext;
  logic [4:0] r_phase, w_phaseNext;
  logic [3:0] r_cyc, w_cycNext;
  logic [8:0] r_sil, w_silNext;
  logic       r_oe1, w_oe1Next;

  logic [SSP_W-1:0] w_cntNext;
  logic       w_sample, w_capture, w_holdValidNext;
  logic [7:0] w_rxByte, w_loadByte;
  logic       w_load, w_holdClr, w_bypass;
  logic       w_isMod, w_isDiv1, w_chipLast, w_nxtMod;
  logic [4:0] w_divM1, w_nxtHalf;
  logic [3:0] w_cycM1;

  assign w_cntNext = r_sspCnt + 1'b1;
  assign w_sample  = (r_sspCnt == SSP_LAST);
  assign w_capture = w_sample && r_slotReq && (r_bitIdx == 3'd7);
  assign w_rxByte  = {r_rx, ssp_dout};
  assign w_holdValidNext = (w_capture && !w_bypass) || (r_holdValid && !w_holdClr);

  // A slot is framed only if the hold buffer will be empty once this edge settles.
  always_ff @(posedge ck_1356meg or negedge reset_n) begin
    if (!reset_n) begin
      r_sspCnt  <= '0;
      r_sspClk  <= 1'b0;
      r_bitIdx  <= 3'd0;
      r_slotReq <= 1'b0;
      r_rx      <= 7'd0;
    end else begin
      r_sspCnt <= w_cntNext;
      r_sspClk <= (w_cntNext < SSP_HALF);
      if (w_sample) begin
        r_bitIdx <= r_bitIdx + 3'd1;
        if (r_slotReq) r_rx <= {r_rx[5:0], ssp_dout};
        if (r_bitIdx == 3'd7) r_slotReq <= !w_holdValidNext;
      end
    end
  end

  always_ff @(posedge ck_1356meg or negedge reset_n) begin
    if (!reset_n) begin
      r_holdValid <= 1'b0;
      r_hold      <= 8'd0;
    end else begin
      if (w_holdClr) r_holdValid <= 1'b0;
      if (w_capture && !w_bypass) begin
        r_holdValid <= 1'b1;
        r_hold      <= w_rxByte;
      end
    end
  end

  assign w_isMod    = ^r_shift[7:6];
  assign w_isDiv1   = (r_shift[7:6] == 2'b10);
  assign w_divM1    = w_isDiv1 ? D1_M1 : D0_M1;
  assign w_cycM1    = w_isDiv1 ? C1_M1 : C0_M1;
  assign w_chipLast = w_isMod ? ((r_phase == w_divM1) && (r_cyc == w_cycM1))
                              : (r_sil == SIL_M1);

  always_ff @(posedge ck_1356meg or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_shift   <= 8'd0;
      r_chipIdx <= 2'd0;
      r_phase   <= 5'd0;
      r_cyc     <= 4'd0;
      r_sil     <= 9'd0;
      r_oe1     <= 1'b0;
    end else begin
      r_state   <= w_stateNext;
      r_shift   <= w_shiftNext;
      r_chipIdx <= w_chipIdxNext;
      r_phase   <= w_phaseNext;
      r_cyc     <= w_cycNext;
      r_sil     <= w_silNext;
      r_oe1     <= w_oe1Next;
    end
  end

  // At the end of the last chip, a capture landing on the same edge bypasses the hold buffer.
  always_comb begin
    w_stateNext   = r_state;
    w_shiftNext   = r_shift;
    w_chipIdxNext = r_chipIdx;
    w_phaseNext   = r_phase;
    w_cycNext     = r_cyc;
    w_silNext     = r_sil;
    w_load        = 1'b0;
    w_loadByte    = r_hold;
    w_holdClr     = 1'b0;
    w_bypass      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_holdValid) begin
          w_load      = 1'b1;
          w_holdClr   = 1'b1;
          w_stateNext = S_RUN;
        end
      end
      S_RUN: begin
        if (w_chipLast) begin
          w_phaseNext = 5'd0;
          w_cycNext   = 4'd0;
          w_silNext   = 9'd0;
          if (r_chipIdx != 2'd3) begin
            w_chipIdxNext = r_chipIdx + 2'd1;
            w_shiftNext   = {r_shift[5:0], 2'b00};
          end else if (r_holdValid) begin
            w_load    = 1'b1;
            w_holdClr = 1'b1;
          end else if (w_capture) begin
            w_load     = 1'b1;
            w_bypass   = 1'b1;
            w_loadByte = w_rxByte;
          end else begin
            w_stateNext = S_IDLE;
          end
        end else if (!w_isMod) begin
          w_silNext = r_sil + 9'd1;
        end else if (r_phase == w_divM1) begin
          w_phaseNext = 5'd0;
          w_cycNext   = r_cyc + 4'd1;
        end else begin
          w_phaseNext = r_phase + 5'd1;
        end
      end
      default: w_stateNext = S_IDLE;
    endcase
    if (w_load) begin
      w_shiftNext   = w_loadByte;
      w_chipIdxNext = 2'd0;
      w_phaseNext   = 5'd0;
      w_cycNext     = 4'd0;
      w_silNext     = 9'd0;
    end
  end

  assign w_nxtMod  = ^w_shiftNext[7:6];
  assign w_nxtHalf = (w_shiftNext[7:6] == 2'b10) ? D1_H : D0_H;
  assign w_oe1Next = (w_stateNext == S_RUN) && w_nxtMod && (w_phaseNext < w_nxtHalf);

`ifdef HI_SIM_FSK_UNDERRUN_STATUS_EN
  logic r_underrun, r_dinSlot;
  logic w_underrun, w_slotEnd, w_flagClr, w_flagNext;

  assign w_underrun = (r_state == S_RUN) && (w_stateNext == S_IDLE);
  assign w_slotEnd  = w_sample && (r_bitIdx == 3'd7);
  assign w_flagClr  = w_slotEnd && r_dinSlot;
  assign w_flagNext = w_underrun || (r_underrun && !w_flagClr);

  // The flag is frozen into r_dinSlot at slot start so the ARM sees a stable bit all slot long.
  always_ff @(posedge ck_1356meg or negedge reset_n) begin
    if (!reset_n) begin
      r_underrun <= 1'b0;
      r_dinSlot  <= 1'b0;
    end else begin
      r_underrun <= w_flagNext;
      if (w_slotEnd) r_dinSlot <= w_flagNext && !w_holdValidNext;
    end
  end

  assign ssp_din = r_dinSlot;
`else
  assign ssp_din = 1'b0;
`endif

  assign ssp_clk   = r_sspClk;
  assign ssp_frame = r_slotReq && (r_bitIdx == 3'd0);
  assign pwr_oe1   = r_oe1;
  assign pwr_lo    = 1'b0;
  assign pwr_hi    = 1'b0;
  assign pwr_oe2   = 1'b0;
  assign pwr_oe3   = 1'b0;
  assign pwr_oe4   = 1'b0;
  assign adc_clk   = 1'b0;

endmodule
